ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 host-side receiver for the keyboard stream that hps_io drives on its ps2_kbd_clk_out / ps2_kbd_data_out pins.
- Synchronises and deglitches the two lines.
- Frames 11-bit device-to-host words and checks odd parity and the stop bit.
- Folds E0/F0 prefixes into one key event per make/break code for the Atari keyboard matrix logic inside the core.
- Receive-only: never drives the lines.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before a filtered line changes (min 1).
TIMEOUT, 60000, CLK cycles without a filtered PS2_CLK edge before a partial frame is abandoned (about 1 ms at system clock).

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
PS2_CLK  in  1  PS/2 clock from hps_io, asynchronous, idle high
PS2_DAT  in  1  PS/2 data from hps_io, asynchronous, idle high
RAW_VALID  out  1  one-cycle pulse: a good frame was received
RAW_BYTE  out  8  last good byte; held between pulses
KEY_VALID  out  1  one-cycle pulse: a complete key event
KEY_CODE  out  8  scancode of the event; held
KEY_EXT  out  1  event was E0-prefixed; held
KEY_RELEASE  out  1  event was F0-prefixed (break); held
PARITY_ERR  out  1  one-cycle pulse: parity mismatch
FRAME_ERR  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout

Behaviour:
Reset:
- All outputs 0; frame state IDLE; prefix flags 0; timeout counter 0.
- Synchroniser and filter registers reset to 1 (lines idle high).
- Asserting reset mid-frame discards the partial frame; no error pulse.

Input conditioning:
- Two-FF synchroniser per line, then a filter.
- The filtered value changes only after FILTER_LEN consecutive samples differ from it.
- Sample event = filtered clock goes 1→0. Filtered data is sampled in the same cycle.

Frame FSM (states IDLE, DATA, PARITY, STOP), advancing on sample events only:
- IDLE:
  - data=0 → DATA, bitcnt=0.
  - data=1 → FRAME_ERR pulse, stay IDLE.
- DATA: shift LSB-first, sr <= {dat, sr[7:1]}. After the 8th bit (bitcnt==7) → PARITY.
- PARITY: store par_ok = ^sr ^ dat (odd parity, so 1 means OK) → STOP.
- STOP, always → IDLE. Checks:
  - dat=0 → FRAME_ERR (takes precedence over parity).
  - else !par_ok → PARITY_ERR.
  - else good frame: RAW_BYTE<=sr and RAW_VALID pulse.
- Latency: the error or valid pulse appears exactly 1 cycle after the cycle containing the stop-bit sample event.

Timeout:
- Counter clears on every filtered clock edge (either direction) and while IDLE, and saturates at TIMEOUT.
- Reaching TIMEOUT while not IDLE → IDLE plus one FRAME_ERR pulse.

Prefix decoder, evaluated in the RAW_VALID cycle using the current flags (KEY_VALID is coincident with RAW_VALID):
- 8'hE0 → ext<=1, no key.
- 8'hF0 → rel<=1, no key.
- 8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: RAW only, flags cleared, no key.
- Any other byte:
  - KEY_VALID pulse.
  - KEY_CODE=byte, KEY_EXT=ext, KEY_RELEASE=rel.
  - Flags cleared.
- PARITY_ERR or FRAME_ERR clears both flags.
- Prefixes accumulate in either order (E0 F0 and F0 E0 both set both flags).

Simultaneous events:
- At most one frame completion per cycle, so error and valid pulses are mutually exclusive.
- A filtered edge in the same cycle the counter reaches TIMEOUT: the edge wins, no timeout.

Decomposition:
Package ps2_pkg holds:
- State enum {IDLE, DATA, PARITY, STOP}.
- Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT_OK=8'hAA, PS2_ECHO=8'hEE, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.

Sub-module ps2_line_filter:
- Synchroniser plus FILTER_LEN deglitch, with fall-edge and any-edge outputs.
- Instantiated once per line.

Test Plan:
1. Frame 0x1C (parity bit 0, stop 1), 40 µs bit period → RAW_VALID with 0x1C; KEY_VALID with KEY_CODE=0x1C, KEY_EXT=0, KEY_RELEASE=0.
2. Frames F0,1C → only one KEY_VALID, on the second frame: code 0x1C, RELEASE=1, EXT=0. Frames E0,F0,75 → one KEY_VALID: code 0x75, EXT=1, RELEASE=1.
3. Frame 0x1C with parity bit 1 preceded by E0 → PARITY_ERR pulse, no RAW/KEY pulse. Next frame 0x1C → KEY_EXT=0 (flag cleared).
4. Stop after 5 data bits with lines held high → FRAME_ERR exactly TIMEOUT cycles after the last edge. A following good 0x29 frame decodes correctly.
5. Clock glitch low for FILTER_LEN-1 cycles while IDLE → no state change, no pulses. Frame 0xAA → RAW_VALID with 0xAA, no KEY_VALID.
6. Assert RESET_N low after 4 bits, release, send 0x16 → outputs 0 during reset, no error pulse, KEY_CODE=0x16 afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Device status/control bytes: reported raw, never turned into key events.
  function automatic logic ps2_is_status(input logic [7:0] b);
    return b inside {PS2_PAUSE, PS2_BAT_OK, PS2_ECHO, PS2_ACK, PS2_RESEND, PS2_ERR0, PS2_ERR1};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Receiver output bundle: raw byte stream, decoded key events and error pulses.
interface ps2_kbd_rx_if;
  logic       RAW_VALID;
  logic [7:0] RAW_BYTE;
  logic       KEY_VALID;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT;
  logic       KEY_RELEASE;
  logic       PARITY_ERR;
  logic       FRAME_ERR;

  modport master (
    output RAW_VALID, RAW_BYTE, KEY_VALID, KEY_CODE, KEY_EXT, KEY_RELEASE, PARITY_ERR, FRAME_ERR
  );

  modport slave (
    input RAW_VALID, RAW_BYTE, KEY_VALID, KEY_CODE, KEY_EXT, KEY_RELEASE, PARITY_ERR, FRAME_ERR
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-FF synchroniser plus run-length deglitch for one PS/2 line (idle high).
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall,
  output logic toggle
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;
  logic            fall_q;
  logic            toggle_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      level_q  <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], line};
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      // cnt_q counts consecutive samples disagreeing with the filtered level.
      if (sync_q[1] != level_q) begin
        if (cnt_q == CntMax) begin
          level_q  <= sync_q[1];
          cnt_q    <= '0;
          toggle_q <= 1'b1;
          fall_q   <= level_q;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level  = level_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames device-to-host words and folds E0/F0 prefixes into key events.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 60000
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          PS2_CLK,
  input  logic          PS2_DAT,
  ps2_kbd_rx_if.master  bus
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax  = ToW'(TIMEOUT);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  logic clk_level, clk_fall, clk_toggle;
  logic dat_level, dat_fall, dat_toggle;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys (CLK),
    .rst_n   (RESET_N),
    .line    (PS2_CLK),
    .level   (clk_level),
    .fall    (clk_fall),
    .toggle  (clk_toggle)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk_sys (CLK),
    .rst_n   (RESET_N),
    .line    (PS2_DAT),
    .level   (dat_level),
    .fall    (dat_fall),
    .toggle  (dat_toggle)
  );

  logic unused_ok;
  assign unused_ok = ^{clk_level, dat_fall, dat_toggle};

  ps2_state_e     state_q;
  logic [2:0]     bitcnt_q;
  logic [7:0]     sr_q;
  logic           par_ok_q;
  logic           ext_q;
  logic           rel_q;
  logic [ToW-1:0] to_q;

  logic       raw_valid_q;
  logic [7:0] raw_byte_q;
  logic       key_valid_q;
  logic [7:0] key_code_q;
  logic       key_ext_q;
  logic       key_release_q;
  logic       parity_err_q;
  logic       frame_err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      sr_q          <= '0;
      par_ok_q      <= 1'b0;
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      to_q          <= '0;
      raw_valid_q   <= 1'b0;
      raw_byte_q    <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      raw_valid_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (clk_toggle || state_q == IDLE) begin
        to_q <= '0;
      end else if (to_q != ToMax) begin
        to_q <= to_q + ToW'(1);
      end

      // Timeout only fires when no clock edge arrives in the same cycle.
      if (state_q != IDLE && !clk_toggle && to_q == ToLast) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        rel_q       <= 1'b0;
      end else if (clk_fall) begin
        unique case (state_q)
          IDLE: begin
            if (!dat_level) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              rel_q       <= 1'b0;
            end
          end
          DATA: begin
            sr_q     <= {dat_level, sr_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_ok_q <= ^sr_q ^ dat_level;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat_level) begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              rel_q       <= 1'b0;
            end else if (!par_ok_q) begin
              parity_err_q <= 1'b1;
              ext_q        <= 1'b0;
              rel_q        <= 1'b0;
            end else begin
              raw_valid_q <= 1'b1;
              raw_byte_q  <= sr_q;
              if (sr_q == PS2_EXT) begin
                ext_q <= 1'b1;
              end else if (sr_q == PS2_BRK) begin
                rel_q <= 1'b1;
              end else if (ps2_is_status(sr_q)) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
              end else begin
                key_valid_q   <= 1'b1;
                key_code_q    <= sr_q;
                key_ext_q     <= ext_q;
                key_release_q <= rel_q;
                ext_q         <= 1'b0;
                rel_q         <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.RAW_VALID   = raw_valid_q;
  assign bus.RAW_BYTE    = raw_byte_q;
  assign bus.KEY_VALID   = key_valid_q;
  assign bus.KEY_CODE    = key_code_q;
  assign bus.KEY_EXT     = key_ext_q;
  assign bus.KEY_RELEASE = key_release_q;
  assign bus.PARITY_ERR  = parity_err_q;
  assign bus.FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed scenarios plus randomized frames.
module tb_ps2_kbd_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 600;
  localparam int          HALF       = 40;

  localparam int K_RAW  = 0;
  localparam int K_KEY  = 1;
  localparam int K_PERR = 2;
  localparam int K_FERR = 3;

  typedef struct {
    int          kind;
    logic [7:0]  code;
    logic        ext;
    logic        rel;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned last_rise = 0;
  exp_t sb[$];
  bit ext_m = 1'b0;
  bit rel_m = 1'b0;
  logic [7:0] stat_tab [7] = '{8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int kind, input logic [7:0] code, input logic e,
                               input logic r, input int unsigned lo, input int unsigned hi);
    exp_t x;
    x.kind = kind; x.code = code; x.ext = e; x.rel = r; x.lo = lo; x.hi = hi;
    sb.push_back(x);
  endfunction

  // Reference model: what one complete frame should produce, from the decoding rules.
  function automatic void model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (stop_bad) begin
      push(K_FERR, 8'h00, 1'b0, 1'b0, 0, 0);
      ext_m = 1'b0; rel_m = 1'b0;
    end else if (par_bad) begin
      push(K_PERR, 8'h00, 1'b0, 1'b0, 0, 0);
      ext_m = 1'b0; rel_m = 1'b0;
    end else begin
      push(K_RAW, b, 1'b0, 1'b0, 0, 0);
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) rel_m = 1'b1;
      else if (b inside {8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        ext_m = 1'b0; rel_m = 1'b0;
      end else begin
        push(K_KEY, b, ext_m, rel_m, 0, 0);
        ext_m = 1'b0; rel_m = 1'b0;
      end
    end
  endfunction

  task automatic check_evt(input int kind);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_evt: saw kind %0d, expected no event @cyc %0d", kind, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind) begin
      n_bad++;
      $display("FAIL evt_kind: got kind %0d, expected kind %0d (code %h) @cyc %0d",
               kind, e.kind, e.code, cyc);
      return;
    end
    case (kind)
      K_RAW: if (bus.RAW_BYTE !== e.code) begin
        n_bad++;
        $display("FAIL raw_byte: got %h, expected %h", bus.RAW_BYTE, e.code);
      end
      K_KEY: if ({bus.KEY_CODE, bus.KEY_EXT, bus.KEY_RELEASE} !== {e.code, e.ext, e.rel}) begin
        n_bad++;
        $display("FAIL key_event: got code %h ext %b rel %b, expected code %h ext %b rel %b",
                 bus.KEY_CODE, bus.KEY_EXT, bus.KEY_RELEASE, e.code, e.ext, e.rel);
      end
      K_FERR: if (e.hi != 0 && (cyc < e.lo || cyc > e.hi)) begin
        n_bad++;
        $display("FAIL timeout_time: got cyc %0d, expected within %0d..%0d", cyc, e.lo, e.hi);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RAW_VALID)  check_evt(K_RAW);
      if (bus.KEY_VALID)  check_evt(K_KEY);
      if (bus.PARITY_ERR) check_evt(K_PERR);
      if (bus.FRAME_ERR)  check_evt(K_FERR);
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      last_rise = cyc;
      wait_cyc(HALF / 2);
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic p;
    logic s;
    p = (~^b) ^ par_bad;
    s = stop_bad ? 1'b0 : 1'b1;
    return {s, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    model_frame(b, par_bad, stop_bad);
    send_bits(mk_bits(b, par_bad, stop_bad), 11);
    wait_cyc(HALF);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      wait_cyc(1);
      t++;
    end
    wait_cyc(5);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d events still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [27:0] v;
    @(negedge clk);
    v = {bus.RAW_VALID, bus.RAW_BYTE, bus.KEY_VALID, bus.KEY_CODE, bus.KEY_EXT,
         bus.KEY_RELEASE, bus.PARITY_ERR, bus.FRAME_ERR};
    n_cmp++;
    if (v !== 28'h0) begin
      n_bad++;
      $display("FAIL %s: outputs %h, expected all zero", name, v);
    end
  endtask

  initial begin
    logic [7:0] b;
    int unsigned r;
    bit pb;
    bit sbad;

    rst_n = 1'b0;
    wait_cyc(3);
    check_outputs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);

    // Plain make code.
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain();

    // Break, and extended break with prefixes in both orders.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    wait_drain();

    // Parity error drops the pending E0.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain();

    // Abandoned frame after five data bits, then recovery.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bits(mk_bits(8'h5A, 1'b0, 1'b0), 6);
    push(K_FERR, 8'h00, 1'b0, 1'b0, last_rise + TIMEOUT + 1, last_rise + TIMEOUT + FILTER_LEN + 6);
    ext_m = 1'b0; rel_m = 1'b0;
    wait_drain();
    send_frame(8'h29, 1'b0, 1'b0);
    wait_drain();

    // Short clock glitch while idle, then a status byte.
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(60);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-frame with an E0 pending.
    send_frame(8'hE0, 1'b0, 1'b0);
    wait_drain();
    send_bits(mk_bits(8'h33, 1'b0, 1'b0), 4);
    rst_n = 1'b0;
    ext_m = 1'b0; rel_m = 1'b0;
    wait_cyc(5);
    check_outputs_zero("reset_midframe");
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h16, 1'b0, 1'b0);
    wait_drain();
    n_cmp++;
    if ({bus.KEY_CODE, bus.KEY_EXT, bus.KEY_RELEASE} !== {8'h16, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL key_held: got code %h ext %b rel %b, expected code 16 ext 0 rel 0",
               bus.KEY_CODE, bus.KEY_EXT, bus.KEY_RELEASE);
    end

    // Randomized mix of prefixes, status bytes, keys and corrupted frames.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r == 4) b = stat_tab[$urandom_range(0, 6)];
      else             b = 8'($urandom);
      pb   = ($urandom_range(0, 7) == 0);
      sbad = !pb && ($urandom_range(0, 9) == 0);
      send_frame(b, pb, sbad);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at cyc %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
